// File: rtl/instruction_encode.sv
// RV32I instruction encoder: maps an instruction id plus operands to a 32-bit word and streams
// it, with a byte address, through a one-entry valid/ready output register.
module instruction_encode #(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [5:0]        instr_id,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [31:0]       imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_word,
  output logic [ADDR_W-1:0] out_addr,
  output logic              err,
  output logic [7:0]        err_count
);

  localparam logic [6:0] OpReg    = 7'h33;
  localparam logic [6:0] OpImm    = 7'h13;
  localparam logic [6:0] OpLoad   = 7'h03;
  localparam logic [6:0] OpStore  = 7'h23;
  localparam logic [6:0] OpBranch = 7'h63;
  localparam logic [6:0] OpJal    = 7'h6F;
  localparam logic [6:0] OpJalr   = 7'h67;
  localparam logic [6:0] OpLui    = 7'h37;
  localparam logic [6:0] OpAuipc  = 7'h17;

  typedef enum logic [2:0] {FmtR, FmtI, FmtSh, FmtS, FmtB, FmtJ, FmtU} fmt_e;

  fmt_e        fmt;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [6:0]  opcode;
  logic        legal;
  logic [31:0] enc_word;

  logic              out_valid_q, out_valid_d;
  logic [31:0]       out_word_q, out_word_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              err_q, err_d;
  logic [7:0]        err_count_q, err_count_d;

  logic accept, out_hs;

  // Id decode: select format, opcode and function fields.
  always_comb begin
    fmt    = FmtR;
    f3     = 3'd0;
    f7     = 7'h00;
    opcode = OpReg;
    legal  = 1'b1;
    case (instr_id)
      6'd0:  f3 = 3'd0;
      6'd1:  begin f3 = 3'd0; f7 = 7'h20; end
      6'd2:  f3 = 3'd4;
      6'd3:  f3 = 3'd6;
      6'd4:  f3 = 3'd7;
      6'd5:  f3 = 3'd1;
      6'd6:  f3 = 3'd5;
      6'd7:  begin f3 = 3'd5; f7 = 7'h20; end
      6'd8:  f3 = 3'd2;
      6'd9:  f3 = 3'd3;
      6'd10: begin fmt = FmtI; opcode = OpImm; f3 = 3'd0; end
      6'd11: begin fmt = FmtI; opcode = OpImm; f3 = 3'd4; end
      6'd12: begin fmt = FmtI; opcode = OpImm; f3 = 3'd6; end
      6'd13: begin fmt = FmtI; opcode = OpImm; f3 = 3'd7; end
      6'd14: begin fmt = FmtSh; opcode = OpImm; f3 = 3'd1; end
      6'd15: begin fmt = FmtSh; opcode = OpImm; f3 = 3'd5; end
      6'd16: begin fmt = FmtSh; opcode = OpImm; f3 = 3'd5; f7 = 7'h20; end
      6'd17: begin fmt = FmtI; opcode = OpImm; f3 = 3'd2; end
      6'd18: begin fmt = FmtI; opcode = OpImm; f3 = 3'd3; end
      6'd19: begin fmt = FmtI; opcode = OpLoad; f3 = 3'd0; end
      6'd20: begin fmt = FmtI; opcode = OpLoad; f3 = 3'd1; end
      6'd21: begin fmt = FmtI; opcode = OpLoad; f3 = 3'd2; end
      6'd22: begin fmt = FmtI; opcode = OpLoad; f3 = 3'd4; end
      6'd23: begin fmt = FmtI; opcode = OpLoad; f3 = 3'd5; end
      6'd24: begin fmt = FmtS; opcode = OpStore; f3 = 3'd0; end
      6'd25: begin fmt = FmtS; opcode = OpStore; f3 = 3'd1; end
      6'd26: begin fmt = FmtS; opcode = OpStore; f3 = 3'd2; end
      6'd27: begin fmt = FmtB; opcode = OpBranch; f3 = 3'd0; end
      6'd28: begin fmt = FmtB; opcode = OpBranch; f3 = 3'd1; end
      6'd29: begin fmt = FmtB; opcode = OpBranch; f3 = 3'd4; end
      6'd30: begin fmt = FmtB; opcode = OpBranch; f3 = 3'd5; end
      6'd31: begin fmt = FmtB; opcode = OpBranch; f3 = 3'd6; end
      6'd32: begin fmt = FmtB; opcode = OpBranch; f3 = 3'd7; end
      6'd33: begin fmt = FmtJ; opcode = OpJal; end
      6'd34: begin fmt = FmtI; opcode = OpJalr; f3 = 3'd0; end
      6'd35: begin fmt = FmtU; opcode = OpLui; end
      6'd36: begin fmt = FmtU; opcode = OpAuipc; end
      default: legal = 1'b0;
    endcase
  end

  // Word assembly: only the fields belonging to the selected format reach the output.
  always_comb begin
    enc_word = '0;
    case (fmt)
      FmtR:    enc_word = {f7, rs2, rs1, f3, rd, opcode};
      FmtI:    enc_word = {imm[11:0], rs1, f3, rd, opcode};
      FmtSh:   enc_word = {f7, imm[4:0], rs1, f3, rd, opcode};
      FmtS:    enc_word = {imm[11:5], rs2, rs1, f3, imm[4:0], opcode};
      FmtB:    enc_word = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], opcode};
      FmtJ:    enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
      FmtU:    enc_word = {imm[31:12], rd, opcode};
      default: enc_word = '0;
    endcase
  end

  assign in_ready = ~out_valid_q | out_ready;
  assign accept   = in_valid & in_ready;
  assign out_hs   = out_valid_q & out_ready;

  always_comb begin
    out_valid_d = out_valid_q;
    out_word_d  = out_word_q;
    addr_d      = addr_q;
    err_d       = accept & ~legal;
    err_count_d = err_count_q;
    if (out_hs) begin
      out_valid_d = 1'b0;
      addr_d      = addr_q + ADDR_W'(4);
    end
    // A legal accept in the same cycle as a handshake replaces the word without a bubble.
    if (accept && legal) begin
      out_valid_d = 1'b1;
      out_word_d  = enc_word;
    end
    if (accept && !legal && err_count_q != 8'hFF) begin
      err_count_d = err_count_q + 8'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_word_q  <= '0;
      addr_q      <= ADDR_W'(BASE_ADDR);
      err_q       <= 1'b0;
      err_count_q <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_word_q  <= out_word_d;
      addr_q      <= addr_d;
      err_q       <= err_d;
      err_count_q <= err_count_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_word  = out_word_q;
  assign out_addr  = addr_q;
  assign err       = err_q;
  assign err_count = err_count_q;

endmodule
